// File: rtl/q_learning_engine.sv
// Q-learning datapath: owns the Q-table, searches the next-state row for its max,
// applies a saturating temporal-difference update and writes the result back.
module q_learning_engine #(
    parameter int DATA_WIDTH    = 16,
    parameter int ACTIONS       = 4,
    parameter int STATES        = 16,
    parameter int ACTIONS_WIDTH = (ACTIONS > 1) ? $clog2(ACTIONS) : 1,
    parameter int STATES_WIDTH  = $clog2(STATES),
    parameter int ALPHA_SHIFT   = 1,
    parameter int GAMMA_SHIFT   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_clear,
    input  logic [STATES_WIDTH-1:0]  i_st,
    input  logic [STATES_WIDTH-1:0]  i_next_st,
    input  logic [ACTIONS_WIDTH-1:0] i_at,
    input  logic [DATA_WIDTH-1:0]    i_rt,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_q_new,
    output logic [DATA_WIDTH-1:0]    o_max_q,
    output logic [ACTIONS_WIDTH-1:0] o_at_max
);

    localparam int W = DATA_WIDTH + 3;
    localparam logic [STATES_WIDTH:0]    STATES_L  = (STATES_WIDTH + 1)'(STATES);
    localparam logic [ACTIONS_WIDTH:0]   ACTIONS_L = (ACTIONS_WIDTH + 1)'(ACTIONS);
    localparam logic [STATES_WIDTH-1:0]  LAST_ST   = STATES_WIDTH'(STATES - 1);
    localparam logic [ACTIONS_WIDTH-1:0] LAST_ACT  = ACTIONS_WIDTH'(ACTIONS - 1);
    localparam logic signed [W-1:0] SAT_MAX = {{4{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {{4{1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, CLEAR, READ, MAX, UPDATE, WRITE} state_t;

    state_t state, state_nxt;

    logic signed [DATA_WIDTH-1:0] q_table [STATES][ACTIONS];
    logic signed [DATA_WIDTH-1:0] row_r [ACTIONS];
    logic signed [DATA_WIDTH-1:0] q_r, rt_r, max_r, q_new_sat;
    logic [STATES_WIDTH-1:0]      st_r, next_st_r, clr_cnt;
    logic [ACTIONS_WIDTH-1:0]     at_r, amax_r, idx_r;
    logic                         in_range_r, in_range_in;
    logic signed [W-1:0]          q_w, rt_w, max_w, td_w, q_new_w;

    assign in_range_in = ({1'b0, i_st} < STATES_L) && ({1'b0, i_next_st} < STATES_L)
                      && ({1'b0, i_at} < ACTIONS_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_clear) state_nxt = CLEAR;
                     else if (i_valid) state_nxt = READ;
            CLEAR:   if (clr_cnt == LAST_ST) state_nxt = IDLE;
            READ:    state_nxt = (ACTIONS == 1) ? UPDATE : MAX;
            MAX:     if (idx_r == LAST_ACT) state_nxt = UPDATE;
            UPDATE:  state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == WRITE);
    end

    // Sign-extended TD arithmetic; the 3 guard bits cover the worst-case sum.
    always_comb begin
        q_w     = q_r;
        rt_w    = rt_r;
        max_w   = max_r;
        td_w    = rt_w + max_w - (max_w >>> GAMMA_SHIFT) - q_w;
        q_new_w = q_w + (td_w >>> ALPHA_SHIFT);
        if (q_new_w > SAT_MAX)      q_new_sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (q_new_w < SAT_MIN) q_new_sat = SAT_MIN[DATA_WIDTH-1:0];
        else                        q_new_sat = q_new_w[DATA_WIDTH-1:0];
    end

    // NOTE: the table is a register array, so it can take the async reset like any flop;
    // a RAM macro could not be zeroed this way and would need the CLEAR sweep instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STATES; s++)
                for (int a = 0; a < ACTIONS; a++)
                    q_table[s][a] <= '0;
        end else if (state == CLEAR) begin
            for (int a = 0; a < ACTIONS; a++)
                q_table[clr_cnt][a] <= '0;
        end else if (state == WRITE && in_range_r) begin
            q_table[st_r][at_r] <= o_q_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_r       <= '0;
            next_st_r  <= '0;
            at_r       <= '0;
            rt_r       <= '0;
            q_r        <= '0;
            max_r      <= '0;
            amax_r     <= '0;
            idx_r      <= '0;
            clr_cnt    <= '0;
            in_range_r <= 1'b0;
            o_q_new    <= '0;
            o_max_q    <= '0;
            o_at_max   <= '0;
            for (int a = 0; a < ACTIONS; a++) row_r[a] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    clr_cnt <= '0;
                    if (!i_clear && i_valid) begin
                        st_r       <= i_st;
                        next_st_r  <= i_next_st;
                        at_r       <= i_at;
                        rt_r       <= i_rt;
                        in_range_r <= in_range_in;
                    end
                end
                CLEAR: clr_cnt <= clr_cnt + 1'b1;
                READ: begin
                    // Row is copied before any write, so st == next_st sees the old row.
                    q_r    <= in_range_r ? q_table[st_r][at_r] : '0;
                    max_r  <= in_range_r ? q_table[next_st_r][0] : '0;
                    amax_r <= '0;
                    idx_r  <= ACTIONS_WIDTH'(1);
                    for (int a = 0; a < ACTIONS; a++)
                        row_r[a] <= in_range_r ? q_table[next_st_r][a] : '0;
                end
                MAX: begin
                    if (row_r[idx_r] > max_r) begin
                        max_r  <= row_r[idx_r];
                        amax_r <= idx_r;
                    end
                    idx_r <= idx_r + 1'b1;
                end
                UPDATE: begin
                    o_q_new  <= in_range_r ? q_new_sat : '0;
                    o_max_q  <= max_r;
                    o_at_max <= amax_r;
                end
                default: ;
            endcase
        end
    end

endmodule
